// File: rtl/rom_arb_defs.sv
// Definitions shared by the ROM port arbiter, the fetch unit and the ROM instance.
package rom_arb_defs;

  localparam int ROM_ADDR_W = 10;
  localparam int ROM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP0 = 2'd1,
    ST_RESP1 = 2'd2
  } arb_state_e;

  // Counter wide enough to hold MAX_WAIT, never narrower than one bit.
  function automatic int wait_cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/rom_arb_starve_ctr.sv
// Saturating count of consecutive cycles port 1 has been denied; raises force1 at MAX_WAIT.
module rom_arb_starve_ctr
  import rom_arb_defs::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = wait_cnt_width(MAX_WAIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic p1_req_i,
  input  logic p1_gnt_i,
  output logic force1_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // With MAX_WAIT=0 the hold branch keeps the counter pinned at zero.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_req_i || p1_gnt_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_CNT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force1_o = (MAX_WAIT != 0) && (wait_cnt_q == MAX_CNT);

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for the shared asynchronous-read instruction ROM.
// Port 0 (fetch) has priority; port 1 is guaranteed progress by the starvation counter.
module rom_port_arbiter
  import rom_arb_defs::*;
#(
  parameter int ADDR_W   = ROM_ADDR_W,
  parameter int DATA_W   = ROM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              p1_starved
);

  logic force1;

  rom_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .p1_req_i(p1_req),
    .p1_gnt_i(p1_gnt),
    .force1_o(force1)
  );

  // Grants are suppressed during reset so nothing is captured into a clearing register.
  always_comb begin
    p1_gnt = !rst && p1_req && (!p0_req || force1);
    p0_gnt = !rst && p0_req && !p1_gnt;
  end

  // With no grant the fetch address stays on the ROM.
  assign rom_addr   = p1_gnt ? p1_addr : p0_addr;
  assign p1_starved = force1;

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              p0_rvalid_q;
  logic              p1_rvalid_q;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;

  always_comb begin
    state_d = ST_IDLE;
    if (p0_gnt) begin
      state_d = ST_RESP0;
    end else if (p1_gnt) begin
      state_d = ST_RESP1;
    end
  end

  // Response FSM: rvalid flags are registered alongside the state they decode from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      p0_rvalid_q <= (state_d == ST_RESP0);
      p1_rvalid_q <= (state_d == ST_RESP1);
      if (p0_gnt) begin
        p0_rdata_q <= rom_data;
      end
      if (p1_gnt) begin
        p1_rdata_q <= rom_data;
      end
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed vector table, hand sequences and random traffic
// checked against a cycle-level reference model, on instances with MAX_WAIT=4 and MAX_WAIT=0.
module tb_rom_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  r0, r1;
  logic [9:0]  a0 [2];
  logic [9:0]  a1 [2];
  logic [1:0]  g0, g1, v0, v1, st;
  logic [9:0]  ra [2];
  logic [31:0] d0 [2];
  logic [31:0] d1 [2];
  logic [31:0] rd [2];

  assign rd[0] = 32'hA500_0000 | {22'd0, ra[0]};
  assign rd[1] = 32'hA500_0000 | {22'd0, ra[1]};

  rom_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .p0_req(r0[0]), .p0_addr(a0[0]), .p0_gnt(g0[0]), .p0_rvalid(v0[0]), .p0_rdata(d0[0]),
    .p1_req(r1[0]), .p1_addr(a1[0]), .p1_gnt(g1[0]), .p1_rvalid(v1[0]), .p1_rdata(d1[0]),
    .rom_addr(ra[0]), .rom_data(rd[0]), .p1_starved(st[0])
  );

  rom_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(0)) dut_b (
    .clk(clk), .rst(rst),
    .p0_req(r0[1]), .p0_addr(a0[1]), .p0_gnt(g0[1]), .p0_rvalid(v0[1]), .p0_rdata(d0[1]),
    .p1_req(r1[1]), .p1_addr(a1[1]), .p1_gnt(g1[1]), .p1_rvalid(v1[1]), .p1_rdata(d1[1]),
    .rom_addr(ra[1]), .rom_data(rd[1]), .p1_starved(st[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: denied-streak length, last grant winner and last captured words.
  int          mw [2] = '{4, 0};
  int          wc [2] = '{0, 0};
  int          win [2] = '{-1, -1};
  bit          ev0 [2], ev1 [2];
  logic [31:0] ed0 [2], ed1 [2];

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return 32'hA500_0000 | {22'd0, a};
  endfunction

  task automatic model_step();
    bit forced;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        wc[d] = 0; ev0[d] = 0; ev1[d] = 0; ed0[d] = '0; ed1[d] = '0;
      end
      forced = (mw[d] != 0) && (wc[d] >= mw[d]);
      if (rst)                               win[d] = -1;
      else if (r1[d] && (forced || !r0[d])) win[d] = 1;
      else if (r0[d])                        win[d] = 0;
      else                                   win[d] = -1;
      chk($sformatf("dut%0d p0_gnt", d), {31'd0, g0[d]}, {31'd0, win[d] == 0});
      chk($sformatf("dut%0d p1_gnt", d), {31'd0, g1[d]}, {31'd0, win[d] == 1});
      chk($sformatf("dut%0d rom_addr", d), {22'd0, ra[d]}, {22'd0, (win[d] == 1) ? a1[d] : a0[d]});
      chk($sformatf("dut%0d p0_rvalid", d), {31'd0, v0[d]}, {31'd0, ev0[d]});
      chk($sformatf("dut%0d p1_rvalid", d), {31'd0, v1[d]}, {31'd0, ev1[d]});
      chk($sformatf("dut%0d p0_rdata", d), d0[d], ed0[d]);
      chk($sformatf("dut%0d p1_rdata", d), d1[d], ed1[d]);
      chk($sformatf("dut%0d p1_starved", d), {31'd0, st[d]}, {31'd0, forced});
      if (!rst) begin
        ev0[d] = (win[d] == 0);
        ev1[d] = (win[d] == 1);
        if (win[d] == 0) ed0[d] = rom_word(a0[d]);
        if (win[d] == 1) ed1[d] = rom_word(a1[d]);
        if (r1[d] && win[d] != 1) wc[d] = (wc[d] < mw[d]) ? wc[d] + 1 : wc[d];
        else                      wc[d] = 0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_both(input logic rs, input logic q0, input logic [9:0] ad0,
                            input logic q1, input logic [9:0] ad1);
    rst = rs;
    r0 = {2{q0}}; r1 = {2{q1}};
    a0[0] = ad0; a0[1] = ad0; a1[0] = ad1; a1[1] = ad1;
  endtask

  typedef struct {
    logic rst, r0; logic [9:0] a0; logic r1; logic [9:0] a1;
    logic g0, g1; logic [9:0] ra; logic v0, v1; logic [31:0] d0, d1; logic st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rs, q0, input logic [9:0] ad0, input logic q1,
                              input logic [9:0] ad1, input logic eg0, eg1,
                              input logic [9:0] era, input logic ev_0, ev_1,
                              input logic [31:0] ed_0, ed_1, input logic est);
    vec_t v;
    v.rst = rs; v.r0 = q0; v.a0 = ad0; v.r1 = q1; v.a1 = ad1;
    v.g0 = eg0; v.g1 = eg1; v.ra = era; v.v0 = ev_0; v.v1 = ev_1;
    v.d0 = ed_0; v.d1 = ed_1; v.st = est;
    tbl.push_back(v);
  endfunction

  localparam logic [31:0] A = 32'hA500_0000;

  initial begin
    // Reset with fetch requesting, then fetch from 0 on release.
    for (int i = 0; i < 3; i++) add(1, 1, 10'h000, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    add(0, 1, 10'h000, 0, 10'h000, 1, 0, 10'h000, 0, 0, 0,          0, 0);
    // Port 0 burst 0x010..0x013.
    add(0, 1, 10'h010, 0, 10'h000, 1, 0, 10'h010, 1, 0, A,          0, 0);
    add(0, 1, 10'h011, 0, 10'h000, 1, 0, 10'h011, 1, 0, A | 32'h10, 0, 0);
    add(0, 1, 10'h012, 0, 10'h000, 1, 0, 10'h012, 1, 0, A | 32'h11, 0, 0);
    add(0, 1, 10'h013, 0, 10'h000, 1, 0, 10'h013, 1, 0, A | 32'h12, 0, 0);
    add(0, 0, 10'h013, 0, 10'h000, 0, 0, 10'h013, 1, 0, A | 32'h13, 0, 0);
    // Port 1 alone at the top address.
    add(0, 0, 10'h013, 1, 10'h3FF, 0, 1, 10'h3FF, 0, 0, A | 32'h13, 0, 0);
    add(0, 0, 10'h013, 0, 10'h3FF, 0, 0, 10'h013, 0, 1, A | 32'h13, A | 32'h3FF, 0);
    add(0, 0, 10'h013, 0, 10'h3FF, 0, 0, 10'h013, 0, 0, A | 32'h13, A | 32'h3FF, 0);
    // Both requesting: four fetch grants, then forced port-1 grant.
    add(0, 1, 10'h020, 1, 10'h055, 1, 0, 10'h020, 0, 0, A | 32'h13, A | 32'h3FF, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 10'h020, 1, 10'h055, 1, 0, 10'h020, 1, 0, A | 32'h20, A | 32'h3FF, 0);
    add(0, 1, 10'h020, 1, 10'h055, 0, 1, 10'h055, 1, 0, A | 32'h20, A | 32'h3FF, 1);
    add(0, 1, 10'h020, 0, 10'h055, 1, 0, 10'h020, 0, 1, A | 32'h20, A | 32'h55, 0);
    add(0, 0, 10'h020, 0, 10'h055, 0, 0, 10'h020, 1, 0, A | 32'h20, A | 32'h55, 0);
    add(0, 0, 10'h020, 0, 10'h055, 0, 0, 10'h020, 0, 0, A | 32'h20, A | 32'h55, 0);

    drive_both(1, 0, 10'h000, 0, 10'h000);
    foreach (tbl[i]) begin
      drive_both(tbl[i].rst, tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1);
      sample();
      chk($sformatf("vec%0d p0_gnt", i),    {31'd0, g0[0]}, {31'd0, tbl[i].g0});
      chk($sformatf("vec%0d p1_gnt", i),    {31'd0, g1[0]}, {31'd0, tbl[i].g1});
      chk($sformatf("vec%0d rom_addr", i),  {22'd0, ra[0]}, {22'd0, tbl[i].ra});
      chk($sformatf("vec%0d p0_rvalid", i), {31'd0, v0[0]}, {31'd0, tbl[i].v0});
      chk($sformatf("vec%0d p1_rvalid", i), {31'd0, v1[0]}, {31'd0, tbl[i].v1});
      chk($sformatf("vec%0d p0_rdata", i),  d0[0], tbl[i].d0);
      chk($sformatf("vec%0d p1_rdata", i),  d1[0], tbl[i].d1);
      chk($sformatf("vec%0d p1_starved", i), {31'd0, st[0]}, {31'd0, tbl[i].st});
      $display("[TB] vec %0d rst=%0d req=%0d/%0d gnt=%0d/%0d rom_addr=%h rvalid=%0d/%0d",
               i, rst, r0[0], r1[0], g0[0], g1[0], ra[0], v0[0], v1[0]);
      advance();
    end

    // Strict priority with the guard disabled.
    drive_both(0, 1, 10'h030, 1, 10'h066);
    for (int i = 0; i < 20; i++) begin
      sample();
      chk($sformatf("strict cyc%0d p0_gnt", i),     {31'd0, g0[1]}, 32'd1);
      chk($sformatf("strict cyc%0d p1_gnt", i),     {31'd0, g1[1]}, 32'd0);
      chk($sformatf("strict cyc%0d p1_starved", i), {31'd0, st[1]}, 32'd0);
      advance();
    end
    $display("[TB] strict-priority run: 20 cycles, dut1 p1_gnt held low");

    // Reset during the port-1 response cycle.
    drive_both(0, 0, 10'h030, 1, 10'h100);
    sample();
    chk("rstmid grant a", {31'd0, g1[0]}, 32'd1);
    chk("rstmid grant b", {31'd0, g1[1]}, 32'd1);
    advance();
    drive_both(1, 0, 10'h030, 0, 10'h100);
    sample();
    chk("rstmid p1_rvalid a", {31'd0, v1[0]}, 32'd0);
    chk("rstmid p1_rdata a",  d1[0], 32'd0);
    chk("rstmid p1_rvalid b", {31'd0, v1[1]}, 32'd0);
    chk("rstmid p1_rdata b",  d1[1], 32'd0);
    advance();
    drive_both(0, 0, 10'h030, 0, 10'h100);
    for (int i = 0; i < 5; i++) begin
      sample();
      chk($sformatf("postrst cyc%0d rvalid", i), {28'd0, v0, v1}, 32'd0);
      advance();
    end
    $display("[TB] reset in response cycle: response cancelled, 5 quiet cycles");

    // Random traffic; a pending request keeps its address until the model says granted.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int d = 0; d < 2; d++) begin
        if (!(r0[d] && win[d] != 0) || $urandom_range(0, 9) == 0) begin
          r0[d] = ($urandom_range(0, 3) != 0);
          a0[d] = 10'($urandom);
        end
        if (!(r1[d] && win[d] != 1) || $urandom_range(0, 9) == 0) begin
          r1[d] = ($urandom_range(0, 1) != 0);
          a1[d] = 10'($urandom);
        end
      end
      sample();
      advance();
    end
    $display("[TB] random phase: 1500 cycles on both instances");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single 1024x32 asynchronous-read instruction ROM between two requesters.
- Port 0 is CPU instruction fetch and has priority. Port 1 is a data/debug reader, e.g. a constant-table load or a monitor dump.
- Only the ROM address is driven combinationally. Each port's read data is registered, and valid is asserted one cycle after grant.
- A starvation counter guarantees port 1 forward progress while port 0 requests continuously.

Parameters:
- ADDR_W, 10, ROM word-address width (1024 words).
- DATA_W, 32, ROM word width.
- MAX_WAIT, 4, consecutive cycles port 1 may be denied before it is forced to win. 0 = strict port-0 priority, starvation guard disabled.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 read request, held until granted.
- p0_addr  in  ADDR_W  port 0 word address.
- p0_gnt  out  1  port 0 granted this cycle (combinational).
- p0_rvalid  out  1  p0_rdata valid, one-cycle pulse.
- p0_rdata  out  DATA_W  registered read data for port 0.
- p1_req  in  1  port 1 read request, held until granted.
- p1_addr  in  ADDR_W  port 1 word address.
- p1_gnt  out  1  port 1 granted this cycle (combinational).
- p1_rvalid  out  1  p1_rdata valid, one-cycle pulse.
- p1_rdata  out  DATA_W  registered read data for port 1.
- rom_addr  out  ADDR_W  address to ROM.
- rom_data  in  DATA_W  combinational ROM output.
- p1_starved  out  1  high while the forced-priority condition is active (status only).

Behaviour:
- Reset values (asynchronous on rst=1):
  - p0_rvalid = p1_rvalid = 0; p0_rdata = p1_rdata = 0.
  - wait_cnt = 0; FSM = IDLE.
  - p0_gnt, p1_gnt and rom_addr follow the combinational rules below; both grants are forced to 0 while rst=1.
- Arbitration, combinational, evaluated every cycle; at most one grant per cycle:
  - force1 = (MAX_WAIT != 0) && (wait_cnt == MAX_WAIT).
  - p1_gnt = p1_req && (!p0_req || force1).
  - p0_gnt = p0_req && !p1_gnt.
- ROM address: rom_addr = p1_gnt ? p1_addr : p0_addr. With no grant, p0_addr is passed so fetch addresses stay stable on the ROM.
- Data capture: on the rising edge where pX_gnt=1, pX_rdata <= rom_data. The non-granted port's rdata holds its last value.
- FSM, 3 states, next-state from grants:
  - IDLE: no response this cycle.
  - RESP0: p0_rvalid=1.
  - RESP1: p1_rvalid=1.
  - Any state -> RESP0 if p0_gnt, -> RESP1 if p1_gnt, -> IDLE otherwise.
  - rvalid is decoded from state, so each rvalid is a single-cycle pulse per grant.
  - Back-to-back grants to the same port give consecutive rvalid pulses, one word per cycle.
- Latency: request granted in cycle N -> data and rvalid in cycle N+1. Throughput is 1 word/cycle total.
- Handshake: a requester keeps req and addr stable until it sees gnt. It may change addr or drop req in the cycle after gnt. Dropping req before gnt withdraws the request, with no response.
- Starvation counter, width clog2(MAX_WAIT+1), min 1:
  - Increments when p1_req && !p1_gnt.
  - Clears when p1_gnt or !p1_req.
  - Saturates at MAX_WAIT.
  - p1_starved = force1.
  - When MAX_WAIT=0 the counter stays 0.
- Simultaneous requests, not forced: port 0 wins and port 1's wait_cnt increments.
- Reset mid-transaction: any pending rvalid is cancelled, and no response is produced after rst deasserts. Requesters must reissue.

Decomposition:
- Shared package/header rom_arb_defs:
  - ROM_ADDR_W=10, ROM_DATA_W=32.
  - FSM encodings ST_IDLE=2'd0, ST_RESP0=2'd1, ST_RESP1=2'd2.
  - These are shared with the fetch unit and the ROM instance.
- One natural sub-module: rom_arb_starve_ctr, holding the saturating wait counter and producing force1/p1_starved.

Test Plan:
Bench ROM model: rom[i] = 32'hA500_0000 | i.
1. Reset: rst=1 for 3 cycles while p0_req=1 -> both gnt=0, both rvalid=0, both rdata=0. Release rst -> p0_gnt=1 in the same cycle; p0_rvalid=1 and p0_rdata=A500_0000 (addr 0) next cycle.
2. Port 0 alone, addr 0x010..0x013 back-to-back -> four consecutive p0_rvalid pulses with rdata A500_0010..A500_0013, one per cycle.
3. Port 1 alone, addr 0x3FF -> p1_gnt same cycle, rom_addr=0x3FF; p1_rvalid next cycle with rdata A500_03FF; p0_rdata unchanged.
4. Both requesting continuously, MAX_WAIT=4, p1_addr=0x055 -> p0 granted 4 cycles; cycle 5 p1_starved=1 and p1_gnt=1; p1_rdata=A500_0055 next cycle; counter then clears and p0 resumes.
5. MAX_WAIT=0, both requesting 20 cycles -> p1_gnt never asserts; p1_starved stays 0.
6. p1 granted, then rst pulsed in the response cycle -> p1_rvalid=0 immediately and p1_rdata=0. After release with no req, no rvalid pulses for 5 cycles.
